spike_encoder: RTL and testbench



---
 rtl/spike_encoder.sv | 105 ++++++++++
 tb/tb_spike_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Sigma-delta rate encoder: turns a frame of channel intensities into
// per-tick spike vectors for a round-robin consumer.
module spike_encoder #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int WINDOW = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [HEIGHT*WIDTH-1:0]   in_data,
  output logic [HEIGHT-1:0]         spikes,
  output logic                      tick,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int PW = $clog2(HEIGHT);
  localparam int TW = $clog2(WINDOW) + 1;
  localparam logic [PW-1:0] LAST_PH = PW'(HEIGHT - 1);
  localparam logic [TW-1:0] LAST_T  = TW'(WINDOW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_value [HEIGHT];
  logic [WIDTH-1:0]    r_acc   [HEIGHT];
  logic [PW-1:0]       r_phase;
  logic [TW-1:0]       r_tcnt;
  logic [HEIGHT-1:0]   r_spikes;
  logic                r_done;

  logic [WIDTH:0]      w_sum   [HEIGHT];
  logic [HEIGHT-1:0]   w_carry;
  logic                w_end_tick;
  logic                w_last_tick;

  // One accumulator per channel; the carry out is that channel's spike
  for (genvar g = 0; g < HEIGHT; g++) begin : g_ch
    assign w_sum[g]   = {1'b0, r_acc[g]} + {1'b0, r_value[g]};
    assign w_carry[g] = w_sum[g][WIDTH];
  end

  assign w_end_tick  = (r_phase == LAST_PH);
  assign w_last_tick = (r_tcnt == LAST_T);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_tcnt   <= '0;
      r_spikes <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < HEIGHT; i++) begin
        r_value[i] <= '0;
        r_acc[i]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            // First addition starts from zero, so acc simply takes value
            for (int i = 0; i < HEIGHT; i++) begin
              r_value[i] <= in_data[i*WIDTH +: WIDTH];
              r_acc[i]   <= in_data[i*WIDTH +: WIDTH];
            end
            r_spikes <= '0;
            r_phase  <= '0;
            r_tcnt   <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_phase <= w_end_tick ? '0 : r_phase + 1'b1;
          if (w_end_tick) begin
            if (w_last_tick) begin
              r_spikes <= '0;
              r_done   <= 1'b1;
              r_state  <= IDLE;
            end else begin
              for (int i = 0; i < HEIGHT; i++) begin
                r_acc[i] <= w_sum[i][WIDTH-1:0];
              end
              r_spikes <= w_carry;
              r_tcnt   <= r_tcnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign tick       = busy && (r_phase == '0);
  assign spikes     = r_spikes;
  assign frame_done = r_done;

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboarded bench for spike_encoder: driver queues frames, monitor
// checks spike patterns, counts and frame timing from an arithmetic model.
module tb_spike_encoder;

  localparam int W = 8;
  localparam int H = 7;
  localparam int N = 256;

  typedef logic [H*W-1:0] frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  frame_t        in_data = '0;
  logic [H-1:0]  spikes;
  logic          tick;
  logic          busy;
  logic          frame_done;

  spike_encoder #(.WIDTH(W), .HEIGHT(H), .WINDOW(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .spikes     (spikes),
    .tick       (tick),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  frame_t sb[$];
  int frames_exp = 0;
  int frames_seen = 0;
  int bad_rdy = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Spike in tick k = carry of addition k+1 of v into a 2^W accumulator
  function automatic int exp_bit(input int v, input int k);
    return (((k + 1) * v) >> W) - ((k * v) >> W);
  endfunction

  function automatic int chan(input frame_t f, input int i);
    return int'(f[i*W +: W]);
  endfunction

  // Monitor
  bit           active = 1'b0;
  int           clk_cnt, tidx, ticks, bad_stab, bad_pat;
  int           cnt [H];
  logic [H-1:0] cur;
  frame_t       ef;

  always @(negedge clk) begin
    if (in_ready !== !busy) bad_rdy++;
    if (rst) begin
      if (active) begin
        void'(sb.pop_front());
        active = 1'b0;
      end
    end else begin
      if (busy) begin
        if (!active) begin
          if (sb.size() == 0) begin
            chk("frame_queued", sb.size(), 1);
            ef = '0;
          end else begin
            ef = sb[0];
          end
          active   = 1'b1;
          clk_cnt  = 0;
          tidx     = -1;
          ticks    = 0;
          bad_stab = 0;
          bad_pat  = 0;
          cnt      = '{default: 0};
        end
        if (tick) begin
          tidx++;
          ticks++;
          cur = spikes;
          for (int i = 0; i < H; i++) begin
            if (int'(spikes[i]) != exp_bit(chan(ef, i), tidx)) bad_pat++;
            cnt[i] += int'(spikes[i]);
          end
        end else if (spikes !== cur) begin
          bad_stab++;
        end
        clk_cnt++;
      end
      if (frame_done) begin
        frames_seen++;
        if (!active) begin
          chk("done_with_frame", active, 1);
        end else begin
          void'(sb.pop_front());
          for (int i = 0; i < H; i++)
            chk($sformatf("count_ch%0d", i), cnt[i], (N * chan(ef, i)) >> W);
          chk("frame_len", clk_cnt, N * H);
          chk("tick_count", ticks, N);
          chk("spike_stable", bad_stab, 0);
          chk("spike_pattern", bad_pat, 0);
          chk("done_idle", busy, 0);
          chk("done_spikes", spikes, 0);
          active = 1'b0;
        end
      end
    end
  end

  // Driver; always entered just after a falling edge
  task automatic send(input frame_t d, input bit hold, output bit done_at);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    done_at = frame_done;
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      sb.push_back(d);
      frames_exp++;
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!frame_done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!frame_done) chk("done_timeout", frame_done, 1);
    @(negedge clk);
  endtask

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int i = 0; i < H; i++) f[i*W +: W] = W'(v);
    return f;
  endfunction

  initial begin
    frame_t f0, fa, fb, fr;
    bit     dn;
    int     seen0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_spikes", spikes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 1);

    // Mixed-intensity frame
    f0 = fill(64);
    f0[0*W +: W] = 8'd255;
    f0[1*W +: W] = 8'd0;
    f0[2*W +: W] = 8'd128;
    f0[3*W +: W] = 8'd1;
    send(f0, 1'b0, dn);
    wait_done();

    // Requests while busy are ignored
    send(f0, 1'b0, dn);
    repeat (9) @(negedge clk);
    in_valid = 1'b1;
    in_data  = '1;
    chk("ready_busy_10", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (889) @(negedge clk);
    in_valid = 1'b1;
    in_data  = '1;
    chk("ready_busy_900", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();

    // Reset mid-frame during tick 100
    send(fill(255), 1'b0, dn);
    repeat (700) @(negedge clk);
    chk("pre_rst_spikes", spikes, 7'h7f);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_spikes", spikes, 0);
    chk("mid_rst_ready", in_ready, 1);
    frames_exp--;
    seen0 = frames_seen;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", frames_seen, seen0);
    send(fill(128), 1'b0, dn);
    wait_done();

    // Back-to-back frames with in_valid held high
    fa = frame_t'({$urandom, $urandom});
    fb = frame_t'({$urandom, $urandom});
    send(fa, 1'b1, dn);
    send(fb, 1'b0, dn);
    chk("accept_on_done", dn, 1);
    wait_done();

    // Random frames
    for (int k = 0; k < 3; k++) begin
      fr = frame_t'({$urandom, $urandom});
      send(fr, 1'b0, dn);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("frames_completed", frames_seen, frames_exp);
    chk("scoreboard_empty", sb.size(), 0);
    chk("ready_vs_busy", bad_rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
